// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared types and constants for the boot-time program loader.
//               The default widths and depth match the single-cycle core's
//               instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    // Defaults that track the core's instruction memory configuration
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_MEM_DEPTH   = 256;

    // Byte packing geometry for a 32-bit instruction word
    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_ADDR_SHIFT = 2;

    // Loader control states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RECV    = 3'd1,
        HANDOFF = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } loader_state_t;

endpackage : program_loader_pkg
`default_nettype wire

// File: rtl/program_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_word_packer
// Description : Packs accepted stream bytes little-endian into words. Owns the
//               byte-lane counter and the assembly register, and raises a
//               combinational completion pulse in the cycle the finishing
//               byte is accepted (the parent registers it into the write
//               strobe). Optional feature macro: PROG_LOADER_CHECKSUM_EN,
//               which treats the s_last byte as a mod-256 checksum of all
//               data bytes instead of image data.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader_word_packer
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  clear_i,
    input  logic                  accept_i,
    input  logic [7:0]            byte_i,
    input  logic                  last_i,
    output logic                  word_valid_o,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  end_o,
    output logic                  sum_ok_o
);

    logic [1:0]            lane_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] merged_w;
    logic                  lane_full_w;

    // Current word with the incoming byte dropped into its lane
    assign merged_w    = asm_q | (DATA_WIDTH'(byte_i) << {lane_q, 3'b000});
    assign lane_full_w = (lane_q == 2'(BYTES_PER_WORD - 1));
    assign end_o       = accept_i && last_i;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       data_acc_w;

    // The s_last byte is the checksum; only earlier bytes are image data
    assign data_acc_w   = accept_i && !last_i;
    // A full word completes on lane 3; the checksum flushes any partial word
    assign word_valid_o = (data_acc_w && lane_full_w) || (end_o && (lane_q != 2'd0));
    assign word_o       = end_o ? asm_q : merged_w;
    assign sum_ok_o     = (sum_q == byte_i);

    // Running mod-256 sum of data bytes, restarted with every load
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sum_q <= 8'd0;
        end else if (clear_i) begin
            sum_q <= 8'd0;
        end else if (data_acc_w) begin
            sum_q <= sum_q + byte_i;
        end
    end
`else
    // Without checksums the s_last byte is data and always closes a word
    assign word_valid_o = accept_i && (lane_full_w || last_i);
    assign word_o       = merged_w;
    assign sum_ok_o     = 1'b1;
`endif

    // Lane counter and assembly register; both restart after every word
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            lane_q <= 2'd0;
            asm_q  <= '0;
        end else if (clear_i) begin
            lane_q <= 2'd0;
            asm_q  <= '0;
        end else if (accept_i) begin
            if (word_valid_o || end_o) begin
                lane_q <= 2'd0;
                asm_q  <= '0;
            end else begin
                lane_q <= lane_q + 2'd1;
                asm_q  <= merged_w;
            end
        end
    end

endmodule : program_loader_word_packer
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot stage for the single-cycle core. Receives a byte stream
//               over valid/ready, writes little-endian 32-bit words to
//               instruction memory from byte address 0, then raises
//               prog_ready until the core acknowledges. Optional feature
//               macro: PROG_LOADER_CHECKSUM_EN (checksum byte on s_last).
//               prog_ready rises the cycle after the final write strobe so
//               the last word is in memory before the core is released.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       load_start_i,
    input  logic                       s_valid_i,
    input  logic [7:0]                 s_data_i,
    input  logic                       s_last_i,
    output logic                       s_ready_o,
    output logic                       im_w_en_o,
    output logic [ADDR_WIDTH-1:0]      im_wr_addr_o,
    output logic [DATA_WIDTH-1:0]      im_data_in_o,
    output logic                       prog_ready_o,
    input  logic                       prog_ack_i,
    output logic [$clog2(MEM_DEPTH):0] word_count_o,
    output logic                       loader_busy_o,
    output logic                       loader_done_o,
    output logic                       loader_err_o
);

    localparam int CNT_WIDTH = $clog2(MEM_DEPTH) + 1;

    loader_state_t         state_q;
    logic [CNT_WIDTH-1:0]  word_count_q;
    logic                  im_w_en_q;
    logic [ADDR_WIDTH-1:0] im_wr_addr_q;
    logic [DATA_WIDTH-1:0] im_data_q;
    logic                  prog_ready_q;

    logic                  start_w;
    logic                  accept_w;
    logic                  mem_full_w;
    logic                  pk_word_valid_w;
    logic [DATA_WIDTH-1:0] pk_word_w;
    logic                  pk_end_w;
    logic                  pk_sum_ok_w;

    // A load may only begin from a resting state; requests mid-load are ignored
    assign start_w    = load_start_i &&
                        ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    // Ready depends on state alone, so acceptance is valid while in RECV
    assign accept_w   = s_valid_i && (state_q == RECV);
    assign mem_full_w = (word_count_q == CNT_WIDTH'(MEM_DEPTH));

    program_loader_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_packer (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .clear_i      (start_w),
        .accept_i     (accept_w),
        .byte_i       (s_data_i),
        .last_i       (s_last_i),
        .word_valid_o (pk_word_valid_w),
        .word_o       (pk_word_w),
        .end_o        (pk_end_w),
        .sum_ok_o     (pk_sum_ok_w)
    );

    // Loader FSM with registered memory-write and handoff outputs
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= IDLE;
            word_count_q <= '0;
            im_w_en_q    <= 1'b0;
            im_wr_addr_q <= '0;
            im_data_q    <= '0;
            prog_ready_q <= 1'b0;
        end else begin
            im_w_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (load_start_i) begin
                        state_q      <= RECV;
                        word_count_q <= '0;
                        im_wr_addr_q <= '0;
                        prog_ready_q <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept_w) begin
                        if (pk_word_valid_w && mem_full_w) begin
                            // No room for this word: drop it and stop the load
                            state_q <= ERROR;
                        end else begin
                            if (pk_word_valid_w) begin
                                im_w_en_q    <= 1'b1;
                                im_wr_addr_q <= ADDR_WIDTH'(word_count_q) << WORD_ADDR_SHIFT;
                                im_data_q    <= pk_word_w;
                                word_count_q <= word_count_q + CNT_WIDTH'(1);
                            end
                            if (pk_end_w) begin
                                state_q <= pk_sum_ok_w ? HANDOFF : ERROR;
                            end
                        end
                    end
                end
                HANDOFF: begin
                    // Ack counts only once the core has actually seen prog_ready
                    if (prog_ready_q && prog_ack_i) begin
                        state_q      <= DONE;
                        prog_ready_q <= 1'b0;
                    end else begin
                        prog_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_ready_o     = (state_q == RECV);
    assign loader_busy_o = (state_q == RECV) || (state_q == HANDOFF);
    assign loader_done_o = (state_q == DONE);
    assign loader_err_o  = (state_q == ERROR);
    assign im_w_en_o     = im_w_en_q;
    assign im_wr_addr_o  = im_wr_addr_q;
    assign im_data_in_o  = im_data_q;
    assign prog_ready_o  = prog_ready_q;
    assign word_count_o  = word_count_q;

endmodule : program_loader
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the single-cycle core.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Writes each word sequentially into instruction memory starting at byte address 0.
- After the last word it asserts prog_ready to the core's program counter and holds it until prog_ack returns.

Parameters:
- DATA_WIDTH, 32, instruction word width; only 32 is supported.
- ADDR_WIDTH, 32, instruction memory byte-address width.
- MEM_DEPTH, 256, instruction memory capacity in words.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- arst  in  1  asynchronous active-high reset
- load_start  in  1  single-cycle request to begin a new load
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_last  in  1  marks the final byte of the image
- s_ready  out  1  loader accepts a byte this cycle
- im_w_en  out  1  instruction memory write strobe
- im_wr_addr  out  ADDR_WIDTH  instruction memory byte address, word-aligned
- im_data_in  out  DATA_WIDTH  word to write
- prog_ready  out  1  program loaded, core may start
- prog_ack  in  1  core acknowledges start
- word_count  out  $clog2(MEM_DEPTH)+1  words written in the current load
- loader_busy  out  1  state is RECV or HANDOFF
- loader_done  out  1  state is DONE
- loader_err  out  1  state is ERROR

Behaviour:
- Reset (async, arst=1):
  - state=IDLE.
  - All outputs 0; im_wr_addr=0, word_count=0.
  - Byte lane counter and assembly register cleared.
- Reset mid-load aborts immediately. Partial words are never written. prog_ready drops in the same cycle that arst asserts.
- Handshake: a byte is accepted when s_valid&&s_ready on a rising edge. s_ready is a function of state only (high exactly in RECV).
- States:
  - IDLE: s_ready=0. load_start -> RECV; clear word_count, lane counter, assembly register and address.
  - RECV: s_ready=1.
    - Accepted byte goes to lane lane_cnt, i.e. bits [8*lane_cnt+7 : 8*lane_cnt]; lane_cnt then increments mod 4.
    - The word completes when lane_cnt==3 or s_last.
    - On completion: next cycle im_w_en=1 for exactly one cycle, with im_data_in = assembled word. Unfilled upper lanes are zero. im_wr_addr = 4*word_count.
    - In that same cycle word_count increments and the assembly register and lane_cnt clear.
    - Accepting the next byte concurrently with the write strobe is legal; no bubbles are required.
    - s_last on completion -> HANDOFF, entered the cycle after the write strobe.
  - Overflow: a word completing while word_count==MEM_DEPTH is not written -> ERROR.
  - HANDOFF: prog_ready=1, held until prog_ack is sampled high -> DONE. prog_ready=0 from DONE onward.
  - DONE: load_start -> RECV, with the same clears as from IDLE.
  - ERROR: s_ready=0, loader_err=1. load_start -> RECV, with the same clears; loader_err drops.
- load_start is ignored in RECV and HANDOFF.
- prog_ack outside HANDOFF is ignored.
- s_last with s_valid low has no effect.
- Latency: 1 cycle from the accepting edge of a completing byte to im_w_en. Minimum 4 cycles per word at full rate.
- im_wr_addr and im_data_in are don't-care while im_w_en=0, but hold their last value.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - The byte carrying s_last is an 8-bit checksum, not image data.
  - The loader keeps a running mod-256 sum of every accepted data byte.
  - On the checksum byte, any pending partial word (lane_cnt!=0) is written zero-padded, with the same 1-cycle strobe.
  - If sum==checksum -> HANDOFF; otherwise -> ERROR, and prog_ready is never asserted.
  - The sum clears on every load start.
- Undefined: s_last byte is ordinary data and no sum logic exists.

Decomposition:
- Shared package holds:
  - loader_state_t enum {IDLE, RECV, HANDOFF, DONE, ERROR};
  - localparams BYTES_PER_WORD=4 and WORD_ADDR_SHIFT=2;
  - DATA_WIDTH/ADDR_WIDTH/MEM_DEPTH defaults, consistent with the core's defines.
- One natural sub-module: word_packer, holding the lane counter, assembly register and completion pulse (plus running sum when enabled). The FSM and address/count logic stay in program_loader.

Test Plan:
- Reset then load_start; stream 8 bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00 with s_last on the 8th:
  - expect writes (addr 0, 0x00000013) and (addr 4, 0x00100093);
  - word_count=2, prog_ready=1 until prog_ack, then loader_done=1.
- 5 bytes 0x11,0x22,0x33,0x44,0x55 with s_last on 0x55: expect words 0x44332211 @0 and 0x00000055 @4.
- s_valid toggling every other cycle: bytes land in the same lanes; exactly one im_w_en per 4 accepted bytes; s_ready is never high outside RECV.
- MEM_DEPTH=4, stream 20 bytes: 4 writes at 0..12, no 5th write, loader_err=1, s_ready=0; load_start recovers to RECV with word_count=0.
- arst pulsed after 6 bytes: all outputs 0 immediately; the second partial word is never written; a subsequent full load restarts at addr 0.
- With PROG_LOADER_CHECKSUM_EN:
  - bytes 0x01,0x02,0x03,0x04 then checksum 0x0A -> HANDOFF;
  - same data with 0x0B -> ERROR, prog_ready stays 0.
